mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester SRAM arbiter: fetch (IF) and load/store (MEM) ports share one SRAM.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed MEM priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // Load/store port
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  // Shared SRAM
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_we,
  output logic              sram_oe
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              gnt_mem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic              sram_we_q;
  logic              sram_oe_q;

  logic              mem_pend;
  logic              any_pend;
  logic              gnt_mem_d;
  logic              gnt_store_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_mem_q;
`endif

  assign mem_pend = mem_r_en | mem_w_en;
  assign any_pend = mem_pend | if_req;

  // Grant decision, only consumed while idle.
  always_comb begin
    gnt_mem_d = mem_pend;
`ifdef ARB_ROUND_ROBIN_EN
    if (mem_pend && if_req) begin
      gnt_mem_d = ~last_mem_q;
    end
`endif
    // A simultaneous read and write request is serviced as a store.
    gnt_store_d = gnt_mem_d & mem_w_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      gnt_mem_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_oe_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q  <= 1'b1;
`endif
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_pend) begin
            state_q   <= StAccess;
            cnt_q     <= 4'd0;
            gnt_mem_q <= gnt_mem_d;
            addr_q    <= gnt_mem_d ? mem_addr : if_addr;
            // Fetches carry no write data; keep the last store value on the bus.
            if (gnt_mem_d) begin
              wdata_q <= mem_wdata;
            end
            sram_we_q <= gnt_store_d;
            sram_oe_q <= ~gnt_store_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_mem_q <= gnt_mem_d;
`endif
          end
        end
        StAccess: begin
          if (cnt_q == LastCnt) begin
            state_q   <= StDone;
            sram_we_q <= 1'b0;
            sram_oe_q <= 1'b0;
            if (gnt_mem_q) begin
              mem_rdata_q <= sram_rdata;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= sram_rdata;
              if_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we    = sram_we_q;
  assign sram_oe    = sram_oe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle, plus
// directed scenarios with literal expectations. Honours ARB_ROUND_ROBIN_EN like the DUT.
module tb_mem_arbiter;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_we;
  logic        sram_oe;

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .WAIT_CYCLES (W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is described by the cycle it was granted; everything else is
  // arithmetic on the number of clock edges since then.
  int          now = 0;        // rising edges seen
  bit          m_busy = 0;
  int          m_t_grant = 0;
  bit          m_is_mem = 0;
  bit          m_is_store = 0;
  bit          m_last_mem = 1;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_mem_rdata = '0;

  task automatic model_step();
    int age;
    bit mem_p;
    now++;
    if (rst) begin
      m_busy = 0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_mem_rdata = '0; m_last_mem = 1;
      return;
    end
    if (m_busy) begin
      age = now - m_t_grant;
      // Edge number W after the grant closes the final access cycle.
      if (age == W) begin
        if (m_is_mem) m_mem_rdata = sram_rdata;
        else m_if_rdata = sram_rdata;
      end
      if (age == W + 1) m_busy = 0;
      return;
    end
    mem_p = mem_r_en | mem_w_en;
    if (!(mem_p || if_req)) return;
`ifdef ARB_ROUND_ROBIN_EN
    m_is_mem = (mem_p && if_req) ? !m_last_mem : mem_p;
`else
    m_is_mem = mem_p;
`endif
    m_last_mem = m_is_mem;
    m_is_store = m_is_mem && mem_w_en;
    m_addr     = m_is_mem ? mem_addr : if_addr;
    if (m_is_mem) m_wdata = mem_wdata;
    m_busy     = 1;
    m_t_grant  = now;
  endtask

  task automatic model_compare();
    int  age;
    bit  acc, rdy;
    age = now - m_t_grant;
    acc = m_busy && (age < W);
    rdy = m_busy && (age == W);
    chk("if_ready",   if_ready,   rdy && !m_is_mem);
    chk("mem_ready",  mem_ready,  rdy && m_is_mem);
    chk("sram_we",    sram_we,    acc && m_is_store);
    chk("sram_oe",    sram_oe,    acc && !m_is_store);
    chk("sram_addr",  sram_addr,  m_addr);
    chk("sram_wdata", sram_wdata, m_wdata);
    chk("if_rdata",   if_rdata,   m_if_rdata);
    chk("mem_rdata",  mem_rdata,  m_mem_rdata);
  endtask

  // Compare process: inputs are driven on the falling edge, so they are stable here.
  always @(posedge clk) begin
    model_step();
    #1;
    model_compare();
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    rst = 1'b0; if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  int          oe_cnt, we_cnt, rdy_at, bad, mem_cnt, if_cnt, n_done;
  logic [31:0] rd;
  bit          seq [0:7];

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_sram_addr", sram_addr, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    drain(2);

    // Fetch only.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; sram_rdata = 32'hE3A01005;
    oe_cnt = 0; rdy_at = -1; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if_req = 1'b0;
      if (sram_oe) oe_cnt++;
      if (if_ready) begin rdy_at = i; rd = if_rdata; end
    end
    chk("fetch_oe_cycles", oe_cnt, 4);
    chk("fetch_ready_cycle", rdy_at, 5);
    chk("fetch_rdata", rd, 32'hE3A01005);
    drain(W + 3);

    // Store.
    @(negedge clk);
    mem_w_en = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF;
    we_cnt = 0; bad = 0; mem_cnt = 0; if_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      mem_w_en = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
      if (sram_we) begin
        we_cnt++;
        if (sram_addr !== 32'h400 || sram_wdata !== 32'hDEADBEEF) bad++;
      end
      if (mem_ready) mem_cnt++;
      if (if_ready) if_cnt++;
    end
    chk("store_we_cycles", we_cnt, 4);
    chk("store_bus_values", bad, 0);
    chk("store_mem_ready_pulses", mem_cnt, 1);
    chk("store_if_ready_pulses", if_cnt, 0);
    drain(W + 3);

    // Contention: both requesters held for four transaction slots.
    @(negedge clk);
    if_req = 1'b1; mem_r_en = 1'b1; if_addr = 32'h10; mem_addr = 32'h20;
    n_done = 0; mem_cnt = 0; if_cnt = 0;
    for (int i = 1; i <= 4 * (W + 2); i++) begin
      @(negedge clk);
      if (if_ready || mem_ready) begin
        if (n_done < 8) seq[n_done] = mem_ready;
        n_done++;
      end
      if (mem_ready) mem_cnt++;
      if (if_ready) if_cnt++;
    end
    idle_inputs();
    chk("contention_completions", n_done, 4);
`ifdef ARB_ROUND_ROBIN_EN
    for (int j = 1; j < 4; j++) chk("rr_alternates", seq[j] != seq[j-1], 1'b1);
`else
    chk("fixed_mem_completions", mem_cnt, 4);
    chk("fixed_if_starved", if_cnt, 0);
`endif
    drain(W + 3);

    // Reset during a store's second access cycle.
    @(negedge clk);
    mem_w_en = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h12345678;
    @(negedge clk);
    idle_inputs();
    chk("abort_we_before_reset", sram_we, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_we_cut", sram_we, 1'b0);
    chk("abort_addr_cleared", sram_addr, 32'h0);
    mem_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_ready) mem_cnt++;
      @(negedge clk);
    end
    chk("abort_no_ready", mem_cnt, 0);
    drain(2);

    // Address change while the fetch is in flight.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    bad = 0; rdy_at = -1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if_req = 1'b0; if_addr = 32'h200;
      if (sram_addr !== 32'h100) bad++;
      if (if_ready) rdy_at = i;
    end
    chk("addr_held", bad, 0);
    chk("addr_test_ready_cycle", rdy_at, 5);
    drain(W + 3);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 59) == 0);
      if_req     = ($urandom_range(0, 99) < 50);
      mem_r_en   = ($urandom_range(0, 99) < 30);
      mem_w_en   = ($urandom_range(0, 99) < 20);
      if_addr    = $urandom;
      mem_addr   = $urandom;
      mem_wdata  = $urandom;
      sram_rdata = $urandom;
    end
    drain(W + 3);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
